// File: rtl/alu_issue_stage_if.sv
// Valid/ready handshake bundle for the ALU issue stage.
// Holds the upstream operand channel and the downstream result channel.
interface alu_issue_stage_if #(
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_ctrl;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic [2:0]   out_ctrl;

    // master is the environment: it issues operations and consumes results
    modport master (
        output in_valid, in_a, in_b, in_ctrl, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ctrl
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ctrl, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ctrl
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-register pipeline wrapper around an external combinational ALU:
// operand register feeds the ALU, result register captures its outputs.
module alu_issue_stage #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_stage_if.slave io,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] op_count,
    output logic             zero_sticky
);
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]       c1_q, c1_d;
    logic             s1_v_q, s1_v_d;
    logic [W-1:0]     res_q, res_d;
    logic             zero_q, zero_d;
    logic [2:0]       c2_q, c2_d;
    logic             s2_v_q, s2_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic s2_load;
    logic in_rdy;
    logic accept;
    logic out_hs;

    // in_ready looks through to out_ready so a full pipe can accept and drain together
    assign s2_load = s1_v_q && (!s2_v_q || io.out_ready);
    assign in_rdy  = !s1_v_q || s2_load;
    assign accept  = io.in_valid && in_rdy;
    assign out_hs  = s2_v_q && io.out_ready;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c1_d     = c1_q;
        s1_v_d   = s1_v_q;
        res_d    = res_q;
        zero_d   = zero_q;
        c2_d     = c2_q;
        s2_v_d   = s2_v_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (accept) begin
            a_d    = io.in_a;
            b_d    = io.in_b;
            c1_d   = io.in_ctrl;
            s1_v_d = 1'b1;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            res_d  = alu_result;
            zero_d = alu_zero;
            c2_d   = c1_q;
            s2_v_d = 1'b1;
        end else if (out_hs) begin
            s2_v_d = 1'b0;
        end

        if (clear_stats) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (out_hs) begin
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | zero_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c1_q     <= '0;
            s1_v_q   <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            c2_q     <= '0;
            s2_v_q   <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c1_q     <= c1_d;
            s1_v_q   <= s1_v_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            c2_q     <= c2_d;
            s2_v_q   <= s2_v_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign io.in_ready   = in_rdy;
    assign io.out_valid  = s2_v_q;
    assign io.out_result = res_q;
    assign io.out_zero   = zero_q;
    assign io.out_ctrl   = c2_q;

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = c1_q;
    assign op_count    = cnt_q;
    assign zero_sticky = sticky_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 4-bit ALU model;
// a second instance with a 2-bit counter covers op_count wrap.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.W(4)) bus ();
    alu_issue_stage_if #(.W(4)) bus2 ();

    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_ctrl;
    logic       alu_zero;
    logic       clear_stats;
    logic [7:0] op_count;
    logic       zero_sticky;

    logic [3:0] alu2_a, alu2_b, alu2_result;
    logic [2:0] alu2_ctrl;
    logic       alu2_zero;
    logic       clear2;
    logic [1:0] op_count2;
    logic       zero_sticky2;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return (a < b) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_a, alu_b, alu_ctrl);
    assign alu_zero    = (alu_result == 4'd0);
    assign alu2_result = alu_f(alu2_a, alu2_b, alu2_ctrl);
    assign alu2_zero   = (alu2_result == 4'd0);

    alu_issue_stage #(.W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .io         (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .clear_stats(clear_stats),
        .op_count   (op_count),
        .zero_sticky(zero_sticky)
    );

    alu_issue_stage #(.W(4), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .io         (bus2.slave),
        .alu_a      (alu2_a),
        .alu_b      (alu2_b),
        .alu_ctrl   (alu2_ctrl),
        .alu_result (alu2_result),
        .alu_zero   (alu2_zero),
        .clear_stats(clear2),
        .op_count   (op_count2),
        .zero_sticky(zero_sticky2)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] c);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_ctrl  = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_r;
        logic [1:0] wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset         = 1'b1;
        clear_stats   = 1'b0;
        clear2        = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 3'b000);
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_a     = 4'h0;
        bus2.in_b     = 4'h0;
        bus2.in_ctrl  = 3'b000;
        bus2.out_ready = 1'b0;

        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_alu_a",     32'(alu_a),         32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_op_count",  32'(op_count),      32'd0);
        reset = 1'b0;

        // single op: 5 + 3
        drive(1'b1, 4'h5, 4'h3, 3'b010);
        bus.out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'b000);
        chk("single_alu_a",    32'(alu_a),         32'h5);
        chk("single_alu_b",    32'(alu_b),         32'h3);
        chk("single_alu_ctrl", 32'(alu_ctrl),      32'h2);
        chk("single_early_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("single_out_valid",  32'(bus.out_valid),  32'd1);
        chk("single_out_result", 32'(bus.out_result), 32'h8);
        chk("single_out_zero",   32'(bus.out_zero),   32'd0);
        chk("single_out_ctrl",   32'(bus.out_ctrl),   32'h2);
        tick();
        chk("single_op_count",   32'(op_count),       32'd1);
        chk("single_drained",    32'(bus.out_valid),  32'd0);

        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear_op_count", 32'(op_count), 32'd0);

        // streaming: op i computes i + 1, result of op i-2 visible at iteration i
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b1, 4'(i), 4'h1, 3'b010);
            else        drive(1'b0, 4'h0, 4'h0, 3'b000);
            #1;
            if (i < 16) chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) begin
                exp_r = 4'(i - 1);
                chk("stream_out_valid",  32'(bus.out_valid),  32'd1);
                chk("stream_out_result", 32'(bus.out_result), 32'(exp_r));
            end
            tick();
        end
        chk("stream_done_valid", 32'(bus.out_valid), 32'd0);
        chk("stream_op_count",   32'(op_count),      32'd16);

        // backpressure: 9+2=B then 4+4=8 accepted, third op 1+1 must stall
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h9, 4'h2, 3'b010);
        #1;
        chk("bp_ready0", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 4'h4, 4'h4, 3'b010);
        #1;
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 4'h1, 4'h1, 3'b010);
        #1;
        chk("bp_full_ready",  32'(bus.in_ready),   32'd0);
        chk("bp_out_valid",   32'(bus.out_valid),  32'd1);
        chk("bp_out_result",  32'(bus.out_result), 32'hB);
        tick();
        chk("bp_hold_ready",  32'(bus.in_ready),   32'd0);
        chk("bp_hold_result", 32'(bus.out_result), 32'hB);
        chk("bp_s1_alu_a",    32'(alu_a),          32'h4);
        drive(1'b0, 4'h0, 4'h0, 3'b000);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_drain2_valid",  32'(bus.out_valid),  32'd1);
        chk("bp_drain2_result", 32'(bus.out_result), 32'h8);
        tick();
        chk("bp_empty",    32'(bus.out_valid), 32'd0);
        chk("bp_op_count", 32'(op_count),      32'd18);
        chk("bp_sticky",   32'(zero_sticky),   32'd1);

        // mid-stream reset with both stages full: 3+3 in s2, 1+2 in s1
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h3, 4'h3, 3'b010);
        tick();
        drive(1'b1, 4'h1, 4'h2, 3'b010);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'b000);
        chk("prerst_valid", 32'(bus.out_valid), 32'd1);
        chk("prerst_ready", 32'(bus.in_ready),  32'd0);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_op_count",  32'(op_count),      32'd0);
        chk("midrst_sticky",    32'(zero_sticky),   32'd0);
        tick();
        chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        tick();
        chk("midrst_count_stays", 32'(op_count), 32'd0);

        // zero result: 7 - 7
        drive(1'b1, 4'h7, 4'h7, 3'b110);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'b000);
        tick();
        chk("zero_out_result", 32'(bus.out_result), 32'h0);
        chk("zero_out_zero",   32'(bus.out_zero),   32'd1);
        chk("zero_out_ctrl",   32'(bus.out_ctrl),   32'h6);
        chk("zero_pre_sticky", 32'(zero_sticky),    32'd0);
        tick();
        chk("zero_sticky_set", 32'(zero_sticky), 32'd1);
        chk("zero_op_count",   32'(op_count),    32'd1);

        // clear_stats coincides with a handshake (2+3=5)
        drive(1'b1, 4'h2, 4'h3, 3'b010);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'b000);
        tick();
        chk("clr_hs_valid", 32'(bus.out_valid), 32'd1);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clr_hs_op_count", 32'(op_count),    32'd0);
        chk("clr_hs_sticky",   32'(zero_sticky), 32'd0);
        chk("clr_hs_drained",  32'(bus.out_valid), 32'd0);

        // counter wrap on the 2-bit instance
        bus2.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus2.in_valid = 1'b1;
            bus2.in_a     = 4'(k + 1);
            bus2.in_b     = 4'h0;
            bus2.in_ctrl  = 3'b010;
            tick();
            bus2.in_valid = 1'b0;
            tick();
            tick();
            chk("wrap_op_count", 32'(op_count2), 32'(wrap_exp[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
